png_unfilter: RTL and testbench
===============================

# png_unfilter

Decoder-side inverse of the PNG filter stage. The block consumes filtered scanlines, each a filter-type beat followed by `cfg_w` filtered RGBA pixels, and emits reconstructed RGBA pixels. It reverses the None/Sub/Up/Average/Paeth filters using a one-row line buffer. It sits downstream of the inflate/LZ77 decoder and upstream of the pixel sink, and mirrors the encoder's `start_i`/`done_o` frame control and `val`/`dat` pixel streams.

## Interface
- `SIZE_W_WD`, 12: width of `cfg_w_i`.
- `SIZE_H_WD`, 12: width of `cfg_h_i`.
- `DATA_PXL_WD`, 32: pixel width; 4 bytes, R=[31:24], G=[23:16], B=[15:8], A=[7:0].
- `MAX_W`, 512: line-buffer depth; the maximum legal `cfg_w_i`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_w_i`  in  SIZE_W_WD  image width in pixels; sampled on `start_i`.
- `cfg_h_i`  in  SIZE_H_WD  image height in rows; sampled on `start_i`.
- `start_i`  in  1  one-cycle frame start pulse.
- `done_o`  out  1  one-cycle frame-complete pulse.
- `err_o`  out  1  sticky error flag; cleared on the next accepted `start_i`.
- `val_i`  in  1  input beat valid.
- `dat_i`  in  DATA_PXL_WD  type beat (type in [7:0], [31:8] ignored) or filtered pixel.
- `rdy_o`  out  1  block accepts `dat_i` this cycle; a beat transfers when `val_i && rdy_o`.
- `val_o`  out  1  reconstructed pixel valid.
- `dat_o`  out  DATA_PXL_WD  reconstructed pixel.

## Operation
- FSM states: IDLE, TYPE, PIXEL, DONE.
- IDLE: `start_i` latches `cfg_w_i`/`cfg_h_i`, clears `err_o`, and goes to TYPE. `val_i` is ignored in IDLE.
- `start_i` outside IDLE is ignored.
- If `cfg_w_i==0`, `cfg_h_i==0`, or `cfg_w_i>MAX_W`: set `err_o`, go to DONE, and emit no pixels.
- TYPE: `rdy_o=1`. An accepted beat latches the filter type, sets column=0, and goes to PIXEL.
- Filter type >4 sets `err_o`, and that row is decoded as None.
- PIXEL: `rdy_o=1`. Each accepted beat reconstructs column x.
  - At x==w-1 on a row other than the last, go to TYPE and increment the row counter.
  - At x==w-1 on the last row, go to DONE.
- DONE: `done_o=1` for one cycle, then IDLE.
- Reconstruction is per byte channel and independent, with all sums mod 256.
  - a = left reconstructed byte, 0 at x==0.
  - b = byte above, 0 on row 0.
  - c = above-left byte, 0 at x==0 or on row 0.
- Filter functions:
  - None: x.
  - Sub: x+a.
  - Up: x+b.
  - Average: x+((a+b)>>1), with a 9-bit intermediate sum.
  - Paeth: p=a+b-c in signed 10 bits; pa=|p-a|, pb=|p-b|, pc=|p-c|. Pick a if pa<=pb && pa<=pc, else b if pb<=pc, else c. Result is x+pick.
- Line buffer: 1R1W synchronous RAM, MAX_W x DATA_PXL_WD.
  - Read address always points at the next column to consume; it is issued in TYPE for column 0 and during column x for x+1.
  - The result of column x is written at address x in the cycle it is produced.
  - Registers hold a (previous output) and c (previous b).
  - Row 0 forces b=c=0 regardless of RAM contents.
- Input gaps (`val_i=0`) stall all state, and the RAM read data is held valid across the stall.

## Timing
- Reset values: `val_o=0`, `dat_o=0`, `done_o=0`, `err_o=0`, `rdy_o=0`, FSM in IDLE, all counters 0.
- Latency: a pixel accepted in cycle t appears on `val_o`/`dat_o` in t+1.
- Throughput: one pixel per cycle, and one extra cycle per row for the type beat.
- `done_o` asserts in the cycle after the last `val_o`, never coincident with it.
- For the error-config path, `done_o` asserts one cycle after the DONE entry.
- `rdy_o` is registered from state: high in TYPE and PIXEL, low in IDLE and DONE.
- `rst` mid-frame: immediate return to reset values. A partial row is discarded, and the next `start_i` begins a clean frame.
- Width 1: a=c=0 on every row.
- Height 1: b=c=0 throughout.

## Test plan
- Sequence: w=2, h=1, type 0, then 0x01020304, 0x05060708. Required: `val_o` carries the same two values on consecutive cycles, and `done_o` pulses on the next cycle.
- Sequence: w=3, h=1, type 1 (Sub), then 0x01010101 three times. Required outputs: 0x01010101, 0x02020202, 0x03030303.
- Sequence: w=1, h=2. Row 0 is type 0 with 0x10203040; row 1 is type 2 (Up) with 0xF0F0F0F0. Required outputs: 0x10203040, then 0x00102030 (mod-256 wrap).
- Average/Paeth: w=2, h=2. Row 0 is type 0 with 0x10101010, 0x20202020; row 1 is type 3 with two zero pixels. Required row-1 outputs: 0x08080808, 0x14141414. The same setup with row 0 = 0x0A0A0A0A, 0x14141414 and row 1 type 4 with zeros must output 0x0A0A0A0A, 0x14141414.
- Stalls: random `val_i` gaps during scenario 4. Required: identical output values and order, and `val_o` never asserts without an accepted input.
- Errors:
  - A type beat of 0x07 sets `err_o` and the row passes through unchanged.
  - `cfg_w_i=0` gives `err_o` and a `done_o` pulse with no `val_o`.
  - `rst` asserted mid-row drops all outputs to 0, and a following frame decodes correctly.

Source files
------------

// File: rtl/png_unfilter.sv
// PNG scanline unfilter: reverses None/Sub/Up/Average/Paeth per byte lane
// using a one-row line buffer of previously reconstructed pixels.
module png_unfilter #(
   parameter int SIZE_W_WD   = 12,
   parameter int SIZE_H_WD   = 12,
   parameter int DATA_PXL_WD = 32,
   parameter int MAX_W       = 512
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [SIZE_W_WD-1:0]   cfg_w_i,
   input  logic [SIZE_H_WD-1:0]   cfg_h_i,
   input  logic                   start_i,
   output logic                   done_o,
   output logic                   err_o,
   input  logic                   val_i,
   input  logic [DATA_PXL_WD-1:0] dat_i,
   output logic                   rdy_o,
   output logic                   val_o,
   output logic [DATA_PXL_WD-1:0] dat_o
);

   localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

   typedef enum logic [1:0] {IDLE, TYPE, PIXEL, DONE} state_t;

   state_t                 state;
   logic [SIZE_W_WD-1:0]   w;
   logic [SIZE_W_WD-1:0]   col;
   logic [SIZE_H_WD-1:0]   h;
   logic [SIZE_H_WD-1:0]   row;
   logic [2:0]             ftype;
   logic [DATA_PXL_WD-1:0] a_q;
   logic [DATA_PXL_WD-1:0] c_q;
   logic [DATA_PXL_WD-1:0] rd_q;
   logic [DATA_PXL_WD-1:0] mem [MAX_W];

   logic                   acc;
   logic                   rd_en;
   logic [AW-1:0]          rd_addr;
   logic [DATA_PXL_WD-1:0] pa;
   logic [DATA_PXL_WD-1:0] pb;
   logic [DATA_PXL_WD-1:0] pc;
   logic [DATA_PXL_WD-1:0] recon;
   logic                   cfg_bad;

   function automatic logic [7:0] filt(input logic [2:0] t,
                                       input logic [7:0] x,
                                       input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [7:0] c);
      logic [8:0]        s;
      logic signed [9:0] p;
      logic signed [9:0] da;
      logic signed [9:0] db;
      logic signed [9:0] dc;
      logic [7:0]        pk;
      s  = {1'b0, a} + {1'b0, b};
      p  = $signed({2'b0, a}) + $signed({2'b0, b}) - $signed({2'b0, c});
      da = p - $signed({2'b0, a});
      db = p - $signed({2'b0, b});
      dc = p - $signed({2'b0, c});
      if (da < 0) da = -da;
      if (db < 0) db = -db;
      if (dc < 0) dc = -dc;
      if (da <= db && da <= dc) pk = a;
      else if (db <= dc)        pk = b;
      else                      pk = c;
      unique case (t)
         3'd1:    filt = x + a;
         3'd2:    filt = x + b;
         3'd3:    filt = x + s[8:1];
         3'd4:    filt = x + pk;
         default: filt = x;
      endcase
   endfunction

   assign acc     = val_i && rdy_o;
   assign rd_en   = (state == TYPE) || (state == PIXEL && acc);
   assign rd_addr = (state == TYPE) ? '0 : AW'(col + 1'b1);
   assign cfg_bad = (cfg_w_i == '0) || (cfg_h_i == '0) ||
                    (32'(cfg_w_i) > MAX_W);

   // Row 0 and column 0 see zero neighbours regardless of stale state.
   always_comb begin
      pa = (col == '0) ? '0 : a_q;
      pb = (row == '0) ? '0 : rd_q;
      pc = (col == '0 || row == '0) ? '0 : c_q;
      recon = '0;
      for (int i = 0; i < DATA_PXL_WD / 8; i++) begin
         recon[i*8 +: 8] = filt(ftype, dat_i[i*8 +: 8], pa[i*8 +: 8],
                                pb[i*8 +: 8], pc[i*8 +: 8]);
      end
   end

   always_ff @(posedge clk) begin
      if (state == PIXEL && acc) mem[col[AW-1:0]] <= recon;
      if (rd_en) rd_q <= mem[rd_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         w      <= '0;
         h      <= '0;
         col    <= '0;
         row    <= '0;
         ftype  <= '0;
         a_q    <= '0;
         c_q    <= '0;
         rdy_o  <= 1'b0;
         val_o  <= 1'b0;
         dat_o  <= '0;
         done_o <= 1'b0;
         err_o  <= 1'b0;
      end else begin
         val_o  <= 1'b0;
         done_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start_i) begin
                  w   <= cfg_w_i;
                  h   <= cfg_h_i;
                  row <= '0;
                  col <= '0;
                  if (cfg_bad) begin
                     err_o <= 1'b1;
                     state <= DONE;
                  end else begin
                     err_o <= 1'b0;
                     state <= TYPE;
                     rdy_o <= 1'b1;
                  end
               end
            end
            TYPE: begin
               if (acc) begin
                  col   <= '0;
                  state <= PIXEL;
                  if (dat_i[7:0] > 8'd4) begin
                     ftype <= 3'd0;
                     err_o <= 1'b1;
                  end else begin
                     ftype <= dat_i[2:0];
                  end
               end
            end
            PIXEL: begin
               if (acc) begin
                  val_o <= 1'b1;
                  dat_o <= recon;
                  a_q   <= recon;
                  c_q   <= pb;
                  col   <= col + 1'b1;
                  if (col == w - 1'b1) begin
                     if (row == h - 1'b1) begin
                        state <= DONE;
                        rdy_o <= 1'b0;
                     end else begin
                        row   <= row + 1'b1;
                        state <= TYPE;
                     end
                  end
               end
            end
            DONE: begin
               done_o <= 1'b1;
               rdy_o  <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_png_unfilter.sv
// Directed and randomized frames checked against a per-byte unfilter
// model that works on whole rows held in arrays.
module tb_png_unfilter;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] cfg_w_i;
   logic [11:0] cfg_h_i;
   logic        start_i;
   logic        done_o;
   logic        err_o;
   logic        val_i;
   logic [31:0] dat_i;
   logic        rdy_o;
   logic        val_o;
   logic [31:0] dat_o;

   png_unfilter dut (
      .clk     (clk),
      .rst     (rst),
      .cfg_w_i (cfg_w_i),
      .cfg_h_i (cfg_h_i),
      .start_i (start_i),
      .done_o  (done_o),
      .err_o   (err_o),
      .val_i   (val_i),
      .dat_i   (dat_i),
      .rdy_o   (rdy_o),
      .val_o   (val_o),
      .dat_o   (dat_o)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int done_n = 0;
   int last_val_cyc = -10;
   int done_cyc = -10;
   int coinc = 0;
   int gap_pct = 0;
   logic [31:0] got[$];
   logic [31:0] exp_q[$];
   bit          exp_err;

   int          fw;
   int          fh;
   logic [7:0]  ftyp[8];
   logic [31:0] fpix[8][16];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (val_o) begin
         got.push_back(dat_o);
         last_val_cyc = cyc;
      end
      if (done_o) begin
         done_n++;
         done_cyc = cyc;
      end
      if (val_o && done_o) coinc++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic int paeth(input int a, input int b, input int c);
      int p, da, db, dc;
      p  = a + b - c;
      da = (p > a) ? p - a : a - p;
      db = (p > b) ? p - b : b - p;
      dc = (p > c) ? p - c : c - p;
      if (da <= db && da <= dc) return a;
      if (db <= dc) return b;
      return c;
   endfunction

   task automatic model();
      int cur[16][4];
      int prev[16][4];
      int xv, a, b, c, r;
      logic [31:0] px;
      exp_q.delete();
      exp_err = 1'b0;
      for (int y = 0; y < fh; y++) begin
         if (ftyp[y] > 4) exp_err = 1'b1;
         for (int x = 0; x < fw; x++) begin
            px = 0;
            for (int ch = 0; ch < 4; ch++) begin
               xv = int'(fpix[y][x][24 - 8*ch +: 8]);
               a  = (x > 0) ? cur[x-1][ch] : 0;
               b  = (y > 0) ? prev[x][ch] : 0;
               c  = (x > 0 && y > 0) ? prev[x-1][ch] : 0;
               case (ftyp[y])
                  8'd1:    r = xv + a;
                  8'd2:    r = xv + b;
                  8'd3:    r = xv + (a + b) / 2;
                  8'd4:    r = xv + paeth(a, b, c);
                  default: r = xv;
               endcase
               cur[x][ch] = r % 256;
               px[24 - 8*ch +: 8] = 8'(cur[x][ch]);
            end
            exp_q.push_back(px);
         end
         prev = cur;
      end
   endtask

   task automatic send(input logic [31:0] d);
      int n = 0;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
         @(posedge clk);
         #1;
      end
      val_i = 1'b1;
      dat_i = d;
      while (!rdy_o && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!rdy_o) chk("rdy_timeout", 32'(rdy_o), 32'd1);
      @(posedge clk);
      #1;
      val_i = 1'b0;
      dat_i = $urandom;
   endtask

   task automatic start_frame(input int w, input int h);
      cfg_w_i = 12'(w);
      cfg_h_i = 12'(h);
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string tag);
      int n = 0;
      while (done_n == d0 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_done"}, 32'(done_n - d0), 32'd1);
   endtask

   task automatic run_frame(input string tag);
      int d0;
      model();
      got.delete();
      coinc = 0;
      d0 = done_n;
      start_frame(fw, fh);
      for (int y = 0; y < fh; y++) begin
         send({24'($urandom), ftyp[y]});
         for (int x = 0; x < fw; x++) send(fpix[y][x]);
      end
      wait_done(d0, tag);
      chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk($sformatf("%s_px%0d", tag, i), got[i], exp_q[i]);
      chk({tag, "_err"}, 32'(err_o), 32'(exp_err));
      chk({tag, "_done_after_last"}, 32'(done_cyc), 32'(last_val_cyc + 1));
      chk({tag, "_no_coinc"}, 32'(coinc), 32'd0);
   endtask

   task automatic setup_avg();
      fw = 2; fh = 2;
      ftyp[0] = 8'd0; ftyp[1] = 8'd3;
      fpix[0][0] = 32'h10101010; fpix[0][1] = 32'h20202020;
      fpix[1][0] = 32'h0;        fpix[1][1] = 32'h0;
   endtask

   initial begin
      int d0;
      rst = 1'b1;
      start_i = 1'b0;
      val_i = 1'b0;
      dat_i = '0;
      cfg_w_i = '0;
      cfg_h_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_val", 32'(val_o), 32'd0);
      chk("rst_dat", dat_o, 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_rdy", 32'(rdy_o), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      fw = 2; fh = 1; ftyp[0] = 8'd0;
      fpix[0][0] = 32'h01020304; fpix[0][1] = 32'h05060708;
      run_frame("none");
      chk("none_px0_lit", got.size() > 0 ? got[0] : 32'hx, 32'h01020304);

      fw = 3; fh = 1; ftyp[0] = 8'd1;
      for (int x = 0; x < 3; x++) fpix[0][x] = 32'h01010101;
      run_frame("sub");
      chk("sub_px2_lit", got.size() > 2 ? got[2] : 32'hx, 32'h03030303);

      fw = 1; fh = 2; ftyp[0] = 8'd0; ftyp[1] = 8'd2;
      fpix[0][0] = 32'h10203040; fpix[1][0] = 32'hF0F0F0F0;
      run_frame("up");
      chk("up_px1_lit", got.size() > 1 ? got[1] : 32'hx, 32'h00102030);

      setup_avg();
      run_frame("avg");
      chk("avg_px2_lit", got.size() > 2 ? got[2] : 32'hx, 32'h08080808);
      chk("avg_px3_lit", got.size() > 3 ? got[3] : 32'hx, 32'h14141414);

      fw = 2; fh = 2; ftyp[0] = 8'd0; ftyp[1] = 8'd4;
      fpix[0][0] = 32'h0A0A0A0A; fpix[0][1] = 32'h14141414;
      fpix[1][0] = 32'h0;        fpix[1][1] = 32'h0;
      run_frame("paeth");
      chk("paeth_px3_lit", got.size() > 3 ? got[3] : 32'hx, 32'h14141414);

      setup_avg();
      gap_pct = 50;
      run_frame("avg_stall");
      gap_pct = 0;

      fw = 3; fh = 1; ftyp[0] = 8'h07;
      fpix[0][0] = 32'hDEADBEEF; fpix[0][1] = 32'h11223344;
      fpix[0][2] = 32'h55667788;
      run_frame("badtype");
      chk("badtype_px1_lit", got.size() > 1 ? got[1] : 32'hx, 32'h11223344);

      got.delete();
      d0 = done_n;
      start_frame(0, 3);
      wait_done(d0, "w0");
      chk("w0_noval", 32'(got.size()), 32'd0);
      chk("w0_err", 32'(err_o), 32'd1);

      got.delete();
      d0 = done_n;
      start_frame(513, 1);
      wait_done(d0, "wbig");
      chk("wbig_noval", 32'(got.size()), 32'd0);
      chk("wbig_err", 32'(err_o), 32'd1);

      fw = 4; fh = 2; ftyp[0] = 8'd1;
      for (int x = 0; x < 4; x++) fpix[0][x] = $urandom;
      start_frame(4, 2);
      send(32'h1);
      send(fpix[0][0]);
      send(fpix[0][1]);
      rst = 1'b1;
      #1;
      chk("midrst_val", 32'(val_o), 32'd0);
      chk("midrst_dat", dat_o, 32'd0);
      chk("midrst_rdy", 32'(rdy_o), 32'd0);
      chk("midrst_err", 32'(err_o), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      fw = 3; fh = 2; ftyp[0] = 8'd1; ftyp[1] = 8'd4;
      for (int x = 0; x < 3; x++) begin
         fpix[0][x] = $urandom;
         fpix[1][x] = $urandom;
      end
      run_frame("postrst");

      gap_pct = 30;
      for (int k = 0; k < 12; k++) begin
         fw = $urandom_range(1, 16);
         fh = $urandom_range(1, 8);
         for (int y = 0; y < fh; y++) begin
            ftyp[y] = ($urandom_range(19) == 0) ? 8'd5 :
                      8'($urandom_range(4));
            for (int x = 0; x < fw; x++) fpix[y][x] = $urandom;
         end
         run_frame($sformatf("rnd%0d", k));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
